// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide, WIDTH iterations.
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               b_zero;
  logic [WIDTH-1:0]   opd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;    // original dividend, returned on divide-by-zero
  logic [2*WIDTH-1:0] acc;      // {upper, multiplier} or {rem, quot}

  logic accept, last;
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (state == S_RUN) && (cnt == LAST);
  assign busy   = (state == S_RUN);

  // Operand pre-conditioning at accept
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULDIV_SIGNED_EN
  logic signed_op, a_neg, b_neg;
  logic neg_q, neg_r;
  assign signed_op = op[1];
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
`else
  // op[1] selects nothing in the unsigned-only build
  logic unused_op1;
  assign unused_op1 = op[1];
  assign a_mag      = A;
  assign b_mag      = B;
`endif

  // One multiply iteration: conditional add into upper half (keeping carry), then shift right
  logic [WIDTH:0]       madd;
  logic [2*WIDTH-1:0]   mul_next;
  assign madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd};
  assign mul_next = acc[0] ? {madd, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // One restoring-divide iteration on the shifted remainder (WIDTH+1 bits so nothing is lost)
  logic [WIDTH:0]       rsh;
  logic [WIDTH+1:0]     dsub;
  logic [2*WIDTH-1:0]   div_next;
  assign rsh      = acc[2*WIDTH-1:WIDTH-1];
  assign dsub     = {1'b0, rsh} - {2'b00, opd};
  assign div_next = dsub[WIDTH+1] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] acc_next;
  assign acc_next = is_div ? div_next : mul_next;

  // Result post-processing applied on the final iteration edge
  logic [WIDTH-1:0] res_hi, res_lo;
  always_comb begin
    res_hi = acc_next[2*WIDTH-1:WIDTH];
    res_lo = acc_next[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (is_div) begin
      if (neg_q) res_lo = -acc_next[WIDTH-1:0];
      if (neg_r) res_hi = -acc_next[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {res_hi, res_lo} = -acc_next;
    end
`endif
    if (is_div && b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      opd      <= '0;
      a_raw    <= '0;
      acc      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      done     <= last;
      div_zero <= last && is_div && b_zero;
      case (state)
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            HI    <= res_hi;
            LO    <= res_lo;
            state <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            state  <= S_RUN;
            cnt    <= '0;
            is_div <= op[0];
            b_zero <= (B == '0);
            a_raw  <= A;
            opd    <= b_mag;
            // multiply keeps the multiplier in the low half; divide keeps the dividend there
            acc    <= {{WIDTH{1'b0}}, op[0] ? a_mag : a_mag};
            if (!op[0]) begin
              opd <= a_mag;
              acc <= {{WIDTH{1'b0}}, b_mag};
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO results.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_cnt = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current (negedge) cycle; returns just after the accept edge.
  task automatic start_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    t0 = cyc; busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom_range(3));
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_now(o, a, b);
  endtask

  // Leaves the bench at the negedge where done is sampled high.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - t0), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    // MULTU max x max
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy_e0", 64'(busy), 64'd1);
    wait_done("multu_max");
    chk("multu_max_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);
    chk("multu_max_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    chk("multu_done_pulse", 64'(done), 64'd0);

    // DIVU 100/7, then back-to-back DIVU 7/100 with start held in DONE
    start_op(2'b01, 32'd100, 32'd7);
    wait_done("divu_100_7");
    chk("divu_100_7_hilo", {HI, LO}, {32'd2, 32'd14});
    chk("divu_100_7_dz", 64'(div_zero), 64'd0);
    start_now(2'b01, 32'd7, 32'd100);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold_hilo", {HI, LO}, {32'd2, 32'd14});
    wait_done("divu_7_100");
    chk("divu_7_100_hilo", {HI, LO}, {32'd7, 32'd0});

    // Divide by zero
    start_op(2'b01, 32'h12345678, 32'd0);
    wait_done("divz");
    chk("divz_flag", 64'(div_zero), 64'd1);
    chk("divz_hilo", {HI, LO}, 64'h12345678_FFFFFFFF);
    @(negedge clk);
    chk("divz_flag_drop", 64'(div_zero), 64'd0);

    // MULTU 3x5 with a stray start at iteration 10 and changing operands
    start_op(2'b00, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_hold_hilo", {HI, LO}, 64'h12345678_FFFFFFFF);
    wait_done("mid");
    chk("mid_hilo", {HI, LO}, {32'd0, 32'd15});

    // Reset during iteration 20
    start_op(2'b00, 32'd7, 32'd9);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 64'(done), 64'd0);
    chk("midrst_no_busy", 64'(busy_cnt), 64'd0);
    start_op(2'b00, 32'd7, 32'd9);
    wait_done("after_rst");
    chk("after_rst_hilo", {HI, LO}, {32'd0, 32'd63});

    // Signed ops (unsigned results when the feature is off)
    start_op(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2");
`ifdef MULDIV_SIGNED_EN
    chk("div_m7_2_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
`else
    chk("div_m7_2_hilo", {HI, LO}, 64'h00000001_7FFFFFFC);
`endif
    start_op(2'b10, 32'hFFFFFFFE, 32'd3);
    wait_done("mult_m2_3");
`ifdef MULDIV_SIGNED_EN
    chk("mult_m2_3_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
`else
    chk("mult_m2_3_hilo", {HI, LO}, 64'h00000002_FFFFFFFA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
